// File: rtl/boot_pkg.sv
// Shared definitions for the UART boot-load controller: FSM state encoding,
// the state that means "no load in progress", and default port widths.
package boot_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned CNT_W_DEF  = 16;

  typedef enum logic [2:0] {
    ST_RUN   = 3'd0,
    ST_ARM   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_BOOT  = 3'd4
  } boot_state_t;

  // State in which the CPU owns the memory write port and the UART is held idle.
  localparam boot_state_t LOAD_IDLE_STATE = ST_RUN;

endpackage

// File: rtl/boot_wr_port_mux.sv
// Memory write-port selector: the CPU request passes straight through unless
// the boot controller owns the port, in which case the controller's
// registered write is presented instead and the CPU request is dropped.
module boot_wr_port_mux #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              own,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_waddr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              ctl_we,
  input  logic [ADDR_W-1:0] ctl_waddr,
  input  logic [DATA_W-1:0] ctl_wdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata
);

  // Select the write source; purely combinational so RUN-mode writes see no latency.
  always_comb begin
    if (own) begin
      mem_we    = ctl_we;
      mem_waddr = ctl_waddr;
      mem_wdata = ctl_wdata;
    end else begin
      mem_we    = cpu_we;
      mem_waddr = cpu_waddr;
      mem_wdata = cpu_wdata;
    end
  end

endmodule

// File: rtl/uart_boot_ctrl.sv
// Boot-load controller: keeps the UART idle while the CPU runs, arms it on a
// load request, writes each completed UART word into memory, and releases the
// CPU with a one-cycle reset pulse once the load is finished.
module uart_boot_ctrl
  import boot_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic [DATA_W-1:0] uart_data,
  input  logic [ADDR_W-1:0] uart_addr,
  input  logic              uart_done,
  output logic              uart_rst,
  output logic              cpu_stall,
  output logic              cpu_rst,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_waddr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        state,
  output logic [CNT_W-1:0]  word_cnt
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  boot_state_t       state_r;
  boot_state_t       state_next_s;
  logic              load_req_q_r;
  logic              load_edge_s;
  logic [ADDR_W-1:0] prev_addr_r;
  logic              addr_chg_s;
  logic              wr_en_s;
  logic              cnt_clr_s;
  logic              ctl_we_r;
  logic [ADDR_W-1:0] ctl_waddr_r;
  logic [DATA_W-1:0] ctl_wdata_r;
  logic [CNT_W-1:0]  word_cnt_r;
  logic              own_s;

  assign load_edge_s = load_req & ~load_req_q_r;
  assign addr_chg_s  = (uart_addr != prev_addr_r);
  assign own_s       = (state_r != LOAD_IDLE_STATE);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= LOAD_IDLE_STATE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic; an abort in ARM takes priority over a first word.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (load_edge_s) state_next_s = ST_ARM;
        else             state_next_s = ST_RUN;
      end
      ST_ARM: begin
        if (load_edge_s)     state_next_s = ST_RUN;
        else if (addr_chg_s) state_next_s = ST_LOAD;
        else                 state_next_s = ST_ARM;
      end
      ST_LOAD: begin
        if (uart_done) state_next_s = ST_FLUSH;
        else           state_next_s = ST_LOAD;
      end
      ST_FLUSH: state_next_s = ST_BOOT;
      ST_BOOT:  state_next_s = ST_RUN;
      default:  state_next_s = LOAD_IDLE_STATE;
    endcase
  end

  // FSM output decode from the registered state.
  always_comb begin
    uart_rst  = 1'b1;
    cpu_stall = 1'b0;
    cpu_rst   = 1'b0;
    case (state_r)
      ST_RUN: begin
        uart_rst  = 1'b1;
        cpu_stall = 1'b0;
        cpu_rst   = 1'b0;
      end
      ST_ARM, ST_LOAD, ST_FLUSH: begin
        uart_rst  = 1'b0;
        cpu_stall = 1'b1;
        cpu_rst   = 1'b0;
      end
      ST_BOOT: begin
        uart_rst  = 1'b1;
        cpu_stall = 1'b1;
        cpu_rst   = 1'b1;
      end
      default: begin
        uart_rst  = 1'b1;
        cpu_stall = 1'b0;
        cpu_rst   = 1'b0;
      end
    endcase
  end

  // Decide whether this cycle's address change is a word to write and when to clear the count.
  always_comb begin
    wr_en_s   = 1'b0;
    cnt_clr_s = 1'b0;
    case (state_r)
      ST_RUN: begin
        wr_en_s   = 1'b0;
        cnt_clr_s = load_edge_s;
      end
      ST_ARM: begin
        wr_en_s   = addr_chg_s & ~load_edge_s;
        cnt_clr_s = load_edge_s;
      end
      ST_LOAD, ST_FLUSH: begin
        wr_en_s   = addr_chg_s;
        cnt_clr_s = 1'b0;
      end
      default: begin
        wr_en_s   = 1'b0;
        cnt_clr_s = 1'b0;
      end
    endcase
  end

  // Edge-detect and previous-address history, tracked every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_req_q_r <= 1'b0;
      prev_addr_r  <= '0;
    end else begin
      load_req_q_r <= load_req;
      prev_addr_r  <= uart_addr;
    end
  end

  // Registered controller write: the completed word lives at the address just before uart_addr.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctl_we_r    <= 1'b0;
      ctl_waddr_r <= '0;
      ctl_wdata_r <= '0;
    end else begin
      ctl_we_r <= wr_en_s;
      if (wr_en_s) begin
        ctl_waddr_r <= uart_addr - ADDR_ONE;
        ctl_wdata_r <= uart_data;
      end else begin
        ctl_waddr_r <= ctl_waddr_r;
        ctl_wdata_r <= ctl_wdata_r;
      end
    end
  end

  // Saturating count of words written in the current or last load.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt_r <= '0;
    end else if (cnt_clr_s) begin
      word_cnt_r <= '0;
    end else if (wr_en_s && (word_cnt_r != CNT_MAX)) begin
      word_cnt_r <= word_cnt_r + CNT_ONE;
    end else begin
      word_cnt_r <= word_cnt_r;
    end
  end

  assign state    = state_r;
  assign word_cnt = word_cnt_r;

  boot_wr_port_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_wr_mux (
    .own       (own_s),
    .cpu_we    (cpu_we),
    .cpu_waddr (cpu_waddr),
    .cpu_wdata (cpu_wdata),
    .ctl_we    (ctl_we_r),
    .ctl_waddr (ctl_waddr_r),
    .ctl_wdata (ctl_wdata_r),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata)
  );

endmodule

// File: tb/tb_uart_boot_ctrl.sv
// Directed self-checking bench for uart_boot_ctrl. Inputs change 1 time unit
// after a rising edge; outputs are checked in the same window.
module tb_uart_boot_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_req;
  logic [31:0] uart_data;
  logic [31:0] uart_addr;
  logic        uart_done;
  logic        uart_rst;
  logic        cpu_stall;
  logic        cpu_rst;
  logic        cpu_we;
  logic [31:0] cpu_waddr;
  logic [31:0] cpu_wdata;
  logic        mem_we;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [2:0]  state;
  logic [15:0] word_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  uart_boot_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .load_req  (load_req),
    .uart_data (uart_data),
    .uart_addr (uart_addr),
    .uart_done (uart_done),
    .uart_rst  (uart_rst),
    .cpu_stall (cpu_stall),
    .cpu_rst   (cpu_rst),
    .cpu_we    (cpu_we),
    .cpu_waddr (cpu_waddr),
    .cpu_wdata (cpu_wdata),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .state     (state),
    .word_cnt  (word_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    n_tests++; if (state !== 3'd1) begin n_fail++; $display("FAIL arm_state: got %0d expected 1", state); end
    n_tests++; if (word_cnt !== 16'd0) begin n_fail++; $display("FAIL arm_cnt_clear: got %0d expected 0", word_cnt); end
  endtask

  task automatic test_reset();
    rst = 1'b1; load_req = 1'b0; uart_data = '0; uart_addr = '0; uart_done = 1'b0;
    cpu_we = 1'b0; cpu_waddr = '0; cpu_wdata = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    n_tests++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state); end
    n_tests++; if (uart_rst !== 1'b1) begin n_fail++; $display("FAIL reset_uart_rst: got %b expected 1", uart_rst); end
    n_tests++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_stall: got %b expected 0", cpu_stall); end
    n_tests++; if (cpu_rst !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_rst: got %b expected 0", cpu_rst); end
    n_tests++; if (word_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_word_cnt: got %0d expected 0", word_cnt); end
    n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
  endtask

  task automatic test_run_passthru();
    cpu_we = 1'b1; cpu_waddr = 32'h0000_0010; cpu_wdata = 32'hDEAD_BEEF;
    #1;
    n_tests++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL pass_we: got %b expected 1", mem_we); end
    n_tests++; if (mem_waddr !== 32'h0000_0010) begin n_fail++; $display("FAIL pass_waddr: got %h expected 00000010", mem_waddr); end
    n_tests++; if (mem_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL pass_wdata: got %h expected deadbeef", mem_wdata); end
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    n_tests++; if (state !== 3'd1) begin n_fail++; $display("FAIL pass_arm_state: got %0d expected 1", state); end
    n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL pass_cpu_blocked: got %b expected 0", mem_we); end
    n_tests++; if (cpu_stall !== 1'b1) begin n_fail++; $display("FAIL pass_arm_stall: got %b expected 1", cpu_stall); end
    n_tests++; if (uart_rst !== 1'b0) begin n_fail++; $display("FAIL pass_arm_uart_rst: got %b expected 0", uart_rst); end
    cpu_we = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_load4();
    logic [31:0] exp_data;
    arm();
    for (int i = 0; i < 4; i++) begin
      exp_data = 32'h11 * (i + 1);
      uart_addr = 32'(i + 1);
      uart_data = exp_data;
      tick();
      n_tests++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL load4_we[%0d]: got %b expected 1", i, mem_we); end
      n_tests++; if (mem_waddr !== 32'(i)) begin n_fail++; $display("FAIL load4_waddr[%0d]: got %h expected %h", i, mem_waddr, 32'(i)); end
      n_tests++; if (mem_wdata !== exp_data) begin n_fail++; $display("FAIL load4_wdata[%0d]: got %h expected %h", i, mem_wdata, exp_data); end
      n_tests++; if (word_cnt !== 16'(i + 1)) begin n_fail++; $display("FAIL load4_cnt[%0d]: got %0d expected %0d", i, word_cnt, i + 1); end
      n_tests++; if (state !== 3'd2) begin n_fail++; $display("FAIL load4_state[%0d]: got %0d expected 2", i, state); end
      if (i == 1) load_req = 1'b1;
      tick();
      load_req = 1'b0;
      n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL load4_idle_we[%0d]: got %b expected 0", i, mem_we); end
      n_tests++; if (state !== 3'd2) begin n_fail++; $display("FAIL load4_idle_state[%0d]: got %0d expected 2", i, state); end
    end
    uart_done = 1'b1;
    tick();
    uart_done = 1'b0;
    n_tests++; if (state !== 3'd3) begin n_fail++; $display("FAIL load4_flush_state: got %0d expected 3", state); end
    n_tests++; if (cpu_rst !== 1'b0) begin n_fail++; $display("FAIL load4_flush_cpu_rst: got %b expected 0", cpu_rst); end
    tick();
    n_tests++; if (state !== 3'd4) begin n_fail++; $display("FAIL load4_boot_state: got %0d expected 4", state); end
    n_tests++; if (cpu_rst !== 1'b1) begin n_fail++; $display("FAIL load4_boot_cpu_rst: got %b expected 1", cpu_rst); end
    n_tests++; if (uart_rst !== 1'b1) begin n_fail++; $display("FAIL load4_boot_uart_rst: got %b expected 1", uart_rst); end
    n_tests++; if (cpu_stall !== 1'b1) begin n_fail++; $display("FAIL load4_boot_stall: got %b expected 1", cpu_stall); end
    n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL load4_boot_we: got %b expected 0", mem_we); end
    tick();
    n_tests++; if (state !== 3'd0) begin n_fail++; $display("FAIL load4_run_state: got %0d expected 0", state); end
    n_tests++; if (cpu_rst !== 1'b0) begin n_fail++; $display("FAIL load4_run_cpu_rst: got %b expected 0", cpu_rst); end
    n_tests++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL load4_run_stall: got %b expected 0", cpu_stall); end
    n_tests++; if (word_cnt !== 16'd4) begin n_fail++; $display("FAIL load4_final_cnt: got %0d expected 4", word_cnt); end
    uart_addr = '0;
  endtask

  task automatic test_same_cycle_done();
    arm();
    for (int i = 1; i <= 4; i++) begin
      uart_addr = 32'(i);
      uart_data = 32'h11 * i;
      tick();
    end
    uart_addr = 32'd5; uart_data = 32'h55; uart_done = 1'b1;
    tick();
    uart_done = 1'b0;
    n_tests++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL samecyc_we: got %b expected 1", mem_we); end
    n_tests++; if (mem_waddr !== 32'd4) begin n_fail++; $display("FAIL samecyc_waddr: got %h expected 00000004", mem_waddr); end
    n_tests++; if (mem_wdata !== 32'h55) begin n_fail++; $display("FAIL samecyc_wdata: got %h expected 00000055", mem_wdata); end
    n_tests++; if (word_cnt !== 16'd5) begin n_fail++; $display("FAIL samecyc_cnt: got %0d expected 5", word_cnt); end
    n_tests++; if (state !== 3'd3) begin n_fail++; $display("FAIL samecyc_flush: got %0d expected 3", state); end
    tick();
    n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL samecyc_no_rewrite: got %b expected 0", mem_we); end
    n_tests++; if (cpu_rst !== 1'b1) begin n_fail++; $display("FAIL samecyc_cpu_rst: got %b expected 1", cpu_rst); end
    n_tests++; if (word_cnt !== 16'd5) begin n_fail++; $display("FAIL samecyc_cnt_hold: got %0d expected 5", word_cnt); end
    tick();
    n_tests++; if (state !== 3'd0) begin n_fail++; $display("FAIL samecyc_run: got %0d expected 0", state); end
    n_tests++; if (cpu_rst !== 1'b0) begin n_fail++; $display("FAIL samecyc_cpu_rst_low: got %b expected 0", cpu_rst); end
    uart_addr = '0;
  endtask

  task automatic test_abort();
    arm();
    tick();
    n_tests++; if (state !== 3'd1) begin n_fail++; $display("FAIL abort_wait_arm: got %0d expected 1", state); end
    load_req = 1'b1;
    tick();
    n_tests++; if (state !== 3'd0) begin n_fail++; $display("FAIL abort_state: got %0d expected 0", state); end
    n_tests++; if (cpu_rst !== 1'b0) begin n_fail++; $display("FAIL abort_cpu_rst: got %b expected 0", cpu_rst); end
    n_tests++; if (word_cnt !== 16'd0) begin n_fail++; $display("FAIL abort_cnt: got %0d expected 0", word_cnt); end
    load_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++; if (cpu_rst !== 1'b0) begin n_fail++; $display("FAIL abort_no_pulse[%0d]: got %b expected 0", i, cpu_rst); end
      n_tests++; if (state !== 3'd0) begin n_fail++; $display("FAIL abort_stay_run[%0d]: got %0d expected 0", i, state); end
    end
  endtask

  task automatic test_reset_midload();
    arm();
    uart_addr = 32'd1; uart_data = 32'hA1; tick();
    uart_addr = 32'd2; uart_data = 32'hA2; tick();
    uart_addr = 32'd5; uart_data = 32'hAB; tick();
    n_tests++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL step_we: got %b expected 1", mem_we); end
    n_tests++; if (mem_waddr !== 32'd4) begin n_fail++; $display("FAIL step_waddr: got %h expected 00000004", mem_waddr); end
    n_tests++; if (word_cnt !== 16'd3) begin n_fail++; $display("FAIL step_cnt: got %0d expected 3", word_cnt); end
    rst = 1'b1;
    tick();
    n_tests++; if (state !== 3'd0) begin n_fail++; $display("FAIL midrst_state: got %0d expected 0", state); end
    n_tests++; if (uart_rst !== 1'b1) begin n_fail++; $display("FAIL midrst_uart_rst: got %b expected 1", uart_rst); end
    n_tests++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL midrst_stall: got %b expected 0", cpu_stall); end
    n_tests++; if (word_cnt !== 16'd0) begin n_fail++; $display("FAIL midrst_cnt: got %0d expected 0", word_cnt); end
    n_tests++; if (cpu_rst !== 1'b0) begin n_fail++; $display("FAIL midrst_cpu_rst: got %b expected 0", cpu_rst); end
    n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL midrst_we: got %b expected 0", mem_we); end
    rst = 1'b0;
    uart_addr = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++; if (cpu_rst !== 1'b0) begin n_fail++; $display("FAIL midrst_no_pulse[%0d]: got %b expected 0", i, cpu_rst); end
    end
  endtask

  task automatic test_saturation();
    arm();
    for (int i = 1; i <= 65535; i++) begin
      uart_addr = 32'(i);
      uart_data = 32'(i);
      tick();
    end
    n_tests++; if (word_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_reach: got %h expected ffff", word_cnt); end
    uart_addr = 32'd65536; uart_data = 32'hCAFE;
    tick();
    n_tests++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL sat_we: got %b expected 1", mem_we); end
    n_tests++; if (mem_waddr !== 32'd65535) begin n_fail++; $display("FAIL sat_waddr: got %h expected 0000ffff", mem_waddr); end
    n_tests++; if (mem_wdata !== 32'hCAFE) begin n_fail++; $display("FAIL sat_wdata: got %h expected 0000cafe", mem_wdata); end
    n_tests++; if (word_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got %h expected ffff", word_cnt); end
    uart_done = 1'b1;
    tick();
    uart_done = 1'b0;
    tick();
    tick();
    n_tests++; if (state !== 3'd0) begin n_fail++; $display("FAIL sat_run: got %0d expected 0", state); end
  endtask

  initial begin
    test_reset();
    test_run_passthru();
    test_load4();
    test_same_cycle_done();
    test_abort();
    test_reset_midload();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_boot_ctrl.md
# uart_boot_ctrl

Boot-load controller that sequences the UART receiver/word-queue for loading a program image into memory. It holds the UART idle while the CPU runs, arms it on a load request, and owns the memory write port while words arrive. On completion it releases the CPU through a one-cycle reset pulse. It sits between the UART/queue, the CPU's memory write port and the instruction/data memory.

## Interface
- ADDR_W, 32, word-index width of the UART address and memory address
- DATA_W, 32, word width
- CNT_W, 16, width of the loaded-word counter (saturating)
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- load_req  in  1  debounced load button, level; action on rising edge
- uart_data  in  DATA_W  last completed word from the UART queue
- uart_addr  in  ADDR_W  UART queue address; increments by 1 after each completed word
- uart_done  in  1  UART load finished (max address or idle timeout)
- uart_rst  out  1  holds UART + queue in reset while not loading
- cpu_stall  out  1  CPU frozen (no fetch, no memory access)
- cpu_rst  out  1  one-cycle CPU reset pulse at end of load
- cpu_we, cpu_waddr, cpu_wdata  in  1/ADDR_W/DATA_W  CPU memory write request
- mem_we, mem_waddr, mem_wdata  out  1/ADDR_W/DATA_W  muxed memory write port
- state  out  3  current FSM state, for LEDs
- word_cnt  out  CNT_W  words written in the current/last load

## Operation
- States: RUN=0, ARM=1, LOAD=2, FLUSH=3, BOOT=4.
- RUN: uart_rst=1, cpu_stall=0. The memory port passes the CPU request combinationally. A rising edge on load_req moves to ARM and clears word_cnt.
- ARM: uart_rst=0, cpu_stall=1, and the memory port is owned by the controller. The UART waits for the first byte.
  - A first change of uart_addr from its ARM-entry value moves to LOAD.
  - A second load_req rising edge aborts to RUN with no cpu_rst pulse and word_cnt=0.
- LOAD: each cycle where uart_addr differs from its registered previous value is a new word. The controller issues a write with mem_waddr = uart_addr−1, mem_wdata = uart_data, and increments word_cnt (saturating at all-ones). uart_done moves to FLUSH.
- FLUSH: one cycle. Samples uart_addr once more to catch a word completed in the same cycle as uart_done, writes it if present, then moves to BOOT.
- BOOT: cpu_rst=1 for exactly one cycle, uart_rst=1, cpu_stall=1, then moves to RUN.
- In any state other than RUN, the CPU write request is ignored and not queued.
- load_req edges in LOAD, FLUSH and BOOT are ignored.
- Reset in any state: state=RUN, uart_rst=1, cpu_stall=0, cpu_rst=0, mem_we from the controller=0, word_cnt=0, and the previous-address and load_req edge registers are cleared. A load in progress is abandoned with no partial cpu_rst.

## Timing
- Every controller-driven write is registered. mem_we is high for one cycle, one cycle after the cycle in which uart_addr changed. waddr and wdata are captured in that same cycle.
- In RUN, mem_* equal cpu_* in the same cycle. The mux switches on the registered state.
- Word detection compares full ADDR_W. A step greater than 1 still produces exactly one write, at uart_addr−1.
- If uart_done and an address change occur in the same LOAD cycle, the word is written and the state goes to FLUSH. FLUSH does not write it a second time.
- load_req edge detection uses one register: edge = load_req & ~load_req_q. RUN→ARM occurs on the cycle after the edge.
- Latency from uart_done to the cpu_rst pulse: 2 cycles (LOAD→FLUSH→BOOT). cpu_stall deasserts on the cycle after BOOT.

## Structure
- Shared package (boot_pkg): the state enum, LOAD_IDLE_STATE encoding, and default widths.
- Sub-module boot_wr_port_mux: the combinational selection between the CPU and controller write ports, keyed on an own flag.
- The FSM, edge detect, new-word detect and counter stay in uart_boot_ctrl.

## Test plan
- Reset mid-LOAD after 3 words -> next cycle: state=0, uart_rst=1, cpu_stall=0, word_cnt=0, no cpu_rst pulse.
- RUN with cpu_we=1, waddr=0x10, wdata=0xDEADBEEF -> mem port shows the same values in the same cycle. load_req pulse -> state=1 one cycle later, cpu_we now blocked (mem_we=0).
- Load 4 words (uart_addr 0→1→2→3→4, data 0x11..0x44), then uart_done -> mem writes (0,0x11)…(3,0x44), one cycle each, word_cnt=4. cpu_rst high exactly one cycle, 2 cycles after uart_done, then state=0.
- uart_done in the same cycle as uart_addr 4→5 (data 0x55) -> exactly one write (4,0x55), word_cnt=5, then normal BOOT.
- ARM then a second load_req edge with no UART activity -> state=0, cpu_rst never asserted, word_cnt=0.
- word_cnt at 0xFFFF plus one more word -> write still issued, word_cnt stays 0xFFFF.
